dsp_macc_sequencer: RTL

//  Sequences one MAE DSP slice in accumulate mode (feedback enabled, fixed operand latency) to compute signed dot products.

---
 rtl/dsp_macc_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dsp_macc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_macc_sequencer
//  Purpose  : Drives one MAE DSP slice in accumulate mode to compute signed
//             dot products from a valid/ready operand stream.
//  Options  : DSP_SEQ_TIMEOUT_EN enables the idle-input abort counter.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp_macc_sequencer #(
    parameter int AW       = 18,
    parameter int BW       = 18,
    parameter int PW       = 40,
    parameter int LEN_W    = 8,
    parameter int MULT_LAT = 2,
    parameter int TO_CYC   = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] CFG_LEN,
    output logic             BUSY,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [AW-1:0]    IN_A,
    input  logic [BW-1:0]    IN_B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [PW-1:0]    OUT_P,
    output logic             OUT_ERR,
    output logic [AW-1:0]    DSP_A,
    output logic [BW-1:0]    DSP_B,
    output logic             DSP_ACC_EN,
    output logic             DSP_FDBK_SEL,
    input  logic [PW-1:0]    DSP_P
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic             r_first;
    logic [MULT_LAT:0] r_en_sr;
    logic [MULT_LAT:0] r_fd_sr;
    logic [AW-1:0]    r_dsp_a;
    logic [BW-1:0]    r_dsp_b;
    logic [PW-1:0]    r_out_p;
    logic             r_out_err;

    logic             w_accept;
    logic             w_last;
    logic             w_timeout;
    logic [LEN_W-1:0] w_cnt_nxt;

    assign w_accept  = (r_state == c_RUN) && IN_VALID;
    assign w_cnt_nxt = r_cnt + 1'b1;
    assign w_last    = w_accept && (w_cnt_nxt == r_len);

`ifdef DSP_SEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TO_CYC + 1);

    logic [c_TO_W-1:0] r_idle_cnt;

    always_ff @(posedge CLK) begin
        if (RST || (r_state != c_RUN) || w_accept) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Fires on the TO_CYC-th consecutive cycle without an accepted beat.
    assign w_timeout = (r_state == c_RUN) && !w_accept &&
                       (r_idle_cnt == c_TO_W'(TO_CYC - 1));
    assign OUT_ERR   = r_out_err;
`else
    logic w_unused_to;
    assign w_unused_to = (TO_CYC != 0) || r_out_err;
    assign w_timeout   = 1'b0;
    assign OUT_ERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_en_sr   <= '0;
            r_fd_sr   <= '0;
            r_dsp_a   <= '0;
            r_dsp_b   <= '0;
            r_out_p   <= '0;
            r_out_err <= 1'b0;
        end else begin
            // Pulse tap MULT_LAT lines up with the product reaching the accumulator.
            if (w_timeout) begin
                r_en_sr <= '0;
                r_fd_sr <= '0;
            end else begin
                r_en_sr <= {r_en_sr[MULT_LAT-1:0], w_accept};
                r_fd_sr <= {r_fd_sr[MULT_LAT-1:0], w_accept && !r_first};
            end

            if (w_accept) begin
                r_dsp_a <= IN_A;
                r_dsp_b <= IN_B;
                r_cnt   <= w_cnt_nxt;
                r_first <= 1'b0;
            end

            case (r_state)
                c_IDLE: begin
                    if (START) begin
                        r_len   <= CFG_LEN;
                        r_cnt   <= '0;
                        r_first <= 1'b1;
                        if (CFG_LEN == '0) begin
                            r_out_p   <= '0;
                            r_out_err <= 1'b0;
                            r_state   <= c_DONE;
                        end else begin
                            r_state <= c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (w_timeout) begin
                        r_out_p   <= '0;
                        r_out_err <= 1'b1;
                        r_state   <= c_DONE;
                    end else if (w_last) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // Empty pipe means the last pulse landed one cycle ago.
                    if (r_en_sr == '0) begin
                        r_out_p   <= DSP_P;
                        r_out_err <= 1'b0;
                        r_state   <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (OUT_READY) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign BUSY         = (r_state != c_IDLE);
    assign IN_READY     = (r_state == c_RUN);
    assign OUT_VALID    = (r_state == c_DONE);
    assign OUT_P        = r_out_p;
    assign DSP_A        = r_dsp_a;
    assign DSP_B        = r_dsp_b;
    assign DSP_ACC_EN   = r_en_sr[MULT_LAT];
    assign DSP_FDBK_SEL = r_fd_sr[MULT_LAT];

endmodule
`default_nettype wire
